sdram_bank_sequencer: RTL and testbench
=======================================

// Module: sdram_bank_sequencer
// PURPOSE
//  Per-bank open-row tracker and SDRAM command sequencer; sits directly downstream of the address mapper.
//  Takes one mapped request (bank/row/column, registered by the mapper) and issues PRE/ACT/RD/WR commands.
//  Enforces tRCD/tRP/tRAS per bank; services precharge-all requests from the refresh controller.
// PARAMETERS
//  MAX_CSIZE  11  column address bits
//  MAX_RSIZE  13  row address bits; also width of command address bus (A[MAX_RSIZE-1:0])
//  BA_SIZE    2   bank address bits; NBANKS = 2**BA_SIZE
//  TCNT_SIZE  4   width of timing counters/inputs
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          reset, asynchronous, active-low
//  trcd_i       in   TCNT_SIZE  ACT->RD/WR delay, cycles (quasi-static)
//  trp_i        in   TCNT_SIZE  PRE->ACT delay, cycles (quasi-static)
//  tras_i       in   TCNT_SIZE  ACT->PRE min delay, cycles (quasi-static)
//  req_i        in   1          request valid; held with payload until req_ready_o
//  we_i         in   1          1=write, 0=read
//  bank_i       in   BA_SIZE    mapped bank
//  row_i        in   MAX_RSIZE  mapped row
//  column_i     in   MAX_CSIZE  mapped column
//  req_ready_o  out  1          1-cycle pulse: request consumed (coincides with RD/WR handshake)
//  pall_req_i   in   1          precharge-all request (level, held until pall_ack_o)
//  pall_ack_o   out  1          1-cycle pulse: all banks closed, tRP elapsed
//  cmd_valid_o  out  1          command valid
//  cmd_ready_i  in   1          command accepted by pin driver
//  cmd_o        out  cmd_t      NOP/ACT/PRE/PALL/RD/WR
//  cmd_ba_o     out  BA_SIZE    command bank
//  cmd_addr_o   out  MAX_RSIZE  command address bus
// BEHAVIOUR
//  Reset: cmd_valid_o=0, cmd_o=NOP, cmd_ba_o=0, cmd_addr_o=0, req_ready_o=0, pall_ack_o=0; all banks closed, counters 0.
//  Per bank: open flag, open-row register, cnt_rcd/cnt_rp/cnt_ras; each counter decrements to 0 and saturates.
//  Counter load on command handshake (cmd_valid_o & cmd_ready_i): ACT loads rcd=trcd_i, ras=tras_i; PRE/PALL loads rp=trp_i.
//  Timing met when counter==0; a value of 0 or 1 on a timing input imposes no extra wait beyond the handshake cycle.
//  FSM states: IDLE, PRE, ACT, RW, PALL, PWAIT.
//  IDLE: pall_req_i has priority over req_i when both are high. On req_i, classify bank_i:
//   hit (open, row==row_i) -> RW; miss (open, row!=row_i) -> PRE; closed -> ACT.
//  PRE: assert PRE when cnt_ras[bank]==0; on handshake clear open flag -> ACT.
//  ACT: assert ACT when cnt_rp[bank]==0; on handshake set open, store row_i -> RW.
//  RW: assert RD/WR when cnt_rcd[bank]==0; on handshake pulse req_ready_o -> IDLE.
//  PALL: if no bank open -> PWAIT directly. Else assert PALL once cnt_ras==0 for every open bank; on handshake close all -> PWAIT.
//  PWAIT: wait until every cnt_rp==0, pulse pall_ack_o -> IDLE.
//  pall_req_i is sampled only in IDLE; an in-flight request completes first.
//  cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o are registered; once valid they stay stable until handshake. cmd_o=NOP when not valid.
//  Address bus: ACT addr=row; PRE addr[10]=0; PALL addr[10]=1.
//  RD/WR addr: {col[MAX_CSIZE-1:10], 1'b0, col[9:0]}, zero-extended. A10=0 means no auto-precharge.
//  Back-to-back requests: req_ready_o pulse -> IDLE; the next request can be classified the cycle after.
//  Counters keep running in every state. Reset mid-sequence aborts it; all banks are treated as closed.
// STRUCTURE
//  sdram_ctrl_pkg: cmd_t enum {NOP,ACT,PRE,PALL,RD,WR}; A10 position constant.
//  Sub-module sdram_bank_timer: one instance per bank (generate, NBANKS); holds open flag, row, the three counters,
//   and outputs rcd_ok/rp_ok/ras_ok.
//  Top: FSM plus command register.
// TESTING
//  Reset (trcd=2,trp=2,tras=5); RD bank1 row 0x12 col 0x34 -> ACT ba1 addr 0x12, then RD ba1 addr 0x034 >=2 cycles later; req_ready_o with RD.
//  Same row, WR col 0x35 -> WR directly (no ACT); gap honours any remaining tRCD.
//  RD bank1 row 0x13 issued 1 cycle after ACT -> PRE held until tRAS=5 elapsed, ACT 0x13 >=2 cycles after PRE, then RD.
//  Banks 0 and 2 open, pall_req_i -> PALL addr[10]=1 after tRAS; pall_ack_o after tRP; next RD bank0 issues ACT first.
//  pall_req_i and req_i high together in IDLE -> PALL/ack first, then request.
//  cmd_ready_i held low 3 cycles -> cmd_o/ba/addr stable, no state advance; 11-bit column 0x4FF -> addr 0x8FF.

Source files
------------

// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM command encoding for the bank sequencer and its bank timers.
package sdram_ctrl_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    PRE  = 3'd2,
    PALL = 3'd3,
    RD   = 3'd4,
    WR   = 3'd5
  } cmd_t;

  // Address bit that selects all-bank precharge / auto-precharge.
  localparam int unsigned A10_POS = 10;

endpackage

// File: rtl/sdram_bank_timer.sv
// One bank's open-row state plus its tRCD/tRP/tRAS countdowns.
module sdram_bank_timer #(
  parameter int MAX_RSIZE = 13,
  parameter int TCNT_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 act,
  input  logic                 pre,
  input  logic [MAX_RSIZE-1:0] act_row,
  input  logic [TCNT_SIZE-1:0] trcd,
  input  logic [TCNT_SIZE-1:0] trp,
  input  logic [TCNT_SIZE-1:0] tras,
  output logic                 is_open,
  output logic [MAX_RSIZE-1:0] open_row,
  output logic                 rcd_ok,
  output logic                 rp_ok,
  output logic                 ras_ok
);

  localparam logic [TCNT_SIZE-1:0] CNT_ZERO = {TCNT_SIZE{1'b0}};
  localparam logic [TCNT_SIZE-1:0] CNT_ONE  = {{(TCNT_SIZE-1){1'b0}}, 1'b1};

  logic                 open_r;
  logic [MAX_RSIZE-1:0] row_r;
  logic [TCNT_SIZE-1:0] cnt_rcd_r;
  logic [TCNT_SIZE-1:0] cnt_rp_r;
  logic [TCNT_SIZE-1:0] cnt_ras_r;

  function automatic logic [TCNT_SIZE-1:0] sat_dec(input logic [TCNT_SIZE-1:0] val);
    return (val == CNT_ZERO) ? CNT_ZERO : val - CNT_ONE;
  endfunction

  // The handshake cycle already counts, so a load stores the delay minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_r    <= 1'b0;
      row_r     <= {MAX_RSIZE{1'b0}};
      cnt_rcd_r <= CNT_ZERO;
      cnt_rp_r  <= CNT_ZERO;
      cnt_ras_r <= CNT_ZERO;
    end else begin
      if (act) begin
        open_r <= 1'b1;
        row_r  <= act_row;
      end else if (pre) begin
        open_r <= 1'b0;
      end else begin
        open_r <= open_r;
      end
      cnt_rcd_r <= act ? sat_dec(trcd) : sat_dec(cnt_rcd_r);
      cnt_ras_r <= act ? sat_dec(tras) : sat_dec(cnt_ras_r);
      cnt_rp_r  <= pre ? sat_dec(trp)  : sat_dec(cnt_rp_r);
    end
  end

  assign is_open  = open_r;
  assign open_row = row_r;
  assign rcd_ok   = (cnt_rcd_r == CNT_ZERO);
  assign rp_ok    = (cnt_rp_r == CNT_ZERO);
  assign ras_ok   = (cnt_ras_r == CNT_ZERO);

endmodule

// File: rtl/sdram_bank_sequencer.sv
// Open-row tracking command sequencer: turns one mapped request into PRE/ACT/RD/WR
// and services precharge-all requests, with a registered command output.
module sdram_bank_sequencer
  import sdram_ctrl_pkg::*;
#(
  parameter int MAX_CSIZE = 11,
  parameter int MAX_RSIZE = 13,
  parameter int BA_SIZE   = 2,
  parameter int TCNT_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [TCNT_SIZE-1:0] trcd_i,
  input  logic [TCNT_SIZE-1:0] trp_i,
  input  logic [TCNT_SIZE-1:0] tras_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [BA_SIZE-1:0]   bank_i,
  input  logic [MAX_RSIZE-1:0] row_i,
  input  logic [MAX_CSIZE-1:0] column_i,
  output logic                 req_ready_o,
  input  logic                 pall_req_i,
  output logic                 pall_ack_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output cmd_t                 cmd_o,
  output logic [BA_SIZE-1:0]   cmd_ba_o,
  output logic [MAX_RSIZE-1:0] cmd_addr_o
);

  localparam int NBANKS = 2 ** BA_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ACT   = 3'd2,
    ST_RW    = 3'd3,
    ST_PALL  = 3'd4,
    ST_PWAIT = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic                 cmd_valid_r, cmd_valid_s;
  cmd_t                 cmd_r, cmd_s;
  logic [BA_SIZE-1:0]   cmd_ba_r, cmd_ba_s;
  logic [MAX_RSIZE-1:0] cmd_addr_r, cmd_addr_s;
  logic                 pall_ack_r, pall_ack_s;
  logic                 hs_s;
  logic [MAX_RSIZE-1:0] rw_addr_s;
  logic [NBANKS-1:0]    open_s, rcd_ok_s, rp_ok_s, ras_ok_s, act_bank_s, pre_bank_s;
  logic [MAX_RSIZE-1:0] open_row_s [NBANKS];

  assign hs_s = cmd_valid_r & cmd_ready_i;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign act_bank_s[b] = hs_s && (cmd_r == ACT) && (cmd_ba_r == BA_SIZE'(b));
    assign pre_bank_s[b] = hs_s && (((cmd_r == PRE) && (cmd_ba_r == BA_SIZE'(b))) || (cmd_r == PALL));

    sdram_bank_timer #(
      .MAX_RSIZE (MAX_RSIZE),
      .TCNT_SIZE (TCNT_SIZE)
    ) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .act      (act_bank_s[b]),
      .pre      (pre_bank_s[b]),
      .act_row  (cmd_addr_r),
      .trcd     (trcd_i),
      .trp      (trp_i),
      .tras     (tras_i),
      .is_open  (open_s[b]),
      .open_row (open_row_s[b]),
      .rcd_ok   (rcd_ok_s[b]),
      .rp_ok    (rp_ok_s[b]),
      .ras_ok   (ras_ok_s[b])
    );
  end

  // Column address with A10 forced low (no auto-precharge), upper column bits above it.
  always_comb begin
    rw_addr_s                            = {MAX_RSIZE{1'b0}};
    rw_addr_s[A10_POS-1:0]               = column_i[A10_POS-1:0];
    rw_addr_s[MAX_CSIZE:A10_POS+1]       = column_i[MAX_CSIZE-1:A10_POS];
  end

  // Next state and next command register contents.
  always_comb begin
    state_s     = state_r;
    cmd_valid_s = cmd_valid_r;
    cmd_s       = cmd_r;
    cmd_ba_s    = cmd_ba_r;
    cmd_addr_s  = cmd_addr_r;
    pall_ack_s  = 1'b0;
    if (hs_s) begin
      cmd_valid_s = 1'b0;
      cmd_s       = NOP;
      cmd_ba_s    = {BA_SIZE{1'b0}};
      cmd_addr_s  = {MAX_RSIZE{1'b0}};
    end else begin
      cmd_valid_s = cmd_valid_r;
    end
    case (state_r)
      ST_IDLE: begin
        // The ack cycle still sees the old pall_req_i level, so it is ignored there.
        if (pall_req_i && !pall_ack_r) begin
          state_s = ST_PALL;
        end else if (req_i) begin
          if (!open_s[bank_i])                    state_s = ST_ACT;
          else if (open_row_s[bank_i] == row_i)   state_s = ST_RW;
          else                                    state_s = ST_PRE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (hs_s) begin
          state_s = ST_ACT;
        end else if (!cmd_valid_r && ras_ok_s[bank_i]) begin
          cmd_valid_s = 1'b1;
          cmd_s       = PRE;
          cmd_ba_s    = bank_i;
          cmd_addr_s  = {MAX_RSIZE{1'b0}};
        end else begin
          state_s = ST_PRE;
        end
      end
      ST_ACT: begin
        if (hs_s) begin
          state_s = ST_RW;
        end else if (!cmd_valid_r && rp_ok_s[bank_i]) begin
          cmd_valid_s = 1'b1;
          cmd_s       = ACT;
          cmd_ba_s    = bank_i;
          cmd_addr_s  = row_i;
        end else begin
          state_s = ST_ACT;
        end
      end
      ST_RW: begin
        if (hs_s) begin
          state_s = ST_IDLE;
        end else if (!cmd_valid_r && rcd_ok_s[bank_i]) begin
          cmd_valid_s = 1'b1;
          cmd_s       = we_i ? WR : RD;
          cmd_ba_s    = bank_i;
          cmd_addr_s  = rw_addr_s;
        end else begin
          state_s = ST_RW;
        end
      end
      ST_PALL: begin
        if (hs_s) begin
          state_s = ST_PWAIT;
        end else if (cmd_valid_r) begin
          state_s = ST_PALL;
        end else if (open_s == {NBANKS{1'b0}}) begin
          state_s = ST_PWAIT;
        end else if (&(ras_ok_s | ~open_s)) begin
          cmd_valid_s         = 1'b1;
          cmd_s               = PALL;
          cmd_ba_s            = {BA_SIZE{1'b0}};
          cmd_addr_s          = {MAX_RSIZE{1'b0}};
          cmd_addr_s[A10_POS] = 1'b1;
        end else begin
          state_s = ST_PALL;
        end
      end
      ST_PWAIT: begin
        if (&rp_ok_s) begin
          pall_ack_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_PWAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and registered command/ack outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cmd_valid_r <= 1'b0;
      cmd_r       <= NOP;
      cmd_ba_r    <= {BA_SIZE{1'b0}};
      cmd_addr_r  <= {MAX_RSIZE{1'b0}};
      pall_ack_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_valid_r <= cmd_valid_s;
      cmd_r       <= cmd_s;
      cmd_ba_r    <= cmd_ba_s;
      cmd_addr_r  <= cmd_addr_s;
      pall_ack_r  <= pall_ack_s;
    end
  end

  assign cmd_valid_o = cmd_valid_r;
  assign cmd_o       = cmd_r;
  assign cmd_ba_o    = cmd_ba_r;
  assign cmd_addr_o  = cmd_addr_r;
  assign pall_ack_o  = pall_ack_r;
  assign req_ready_o = hs_s && ((cmd_r == RD) || (cmd_r == WR));

endmodule

// File: tb/tb_sdram_bank_sequencer.sv
// Bench for sdram_bank_sequencer: directed scenarios plus random traffic against an
// open-row model that predicts the command stream and checks timing gaps by cycle count.
module tb_sdram_bank_sequencer;
  import sdram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trcd, trp, tras;
  logic        req, we, pall_req, cmd_ready;
  logic [1:0]  bank;
  logic [12:0] row;
  logic [10:0] column;
  logic        req_ready, pall_ack, cmd_valid;
  cmd_t        cmd;
  logic [1:0]  cmd_ba;
  logic [12:0] cmd_addr;

  sdram_bank_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .trcd_i      (trcd),
    .trp_i       (trp),
    .tras_i      (tras),
    .req_i       (req),
    .we_i        (we),
    .bank_i      (bank),
    .row_i       (row),
    .column_i    (column),
    .req_ready_o (req_ready),
    .pall_req_i  (pall_req),
    .pall_ack_o  (pall_ack),
    .cmd_valid_o (cmd_valid),
    .cmd_ready_i (cmd_ready),
    .cmd_o       (cmd),
    .cmd_ba_o    (cmd_ba),
    .cmd_addr_o  (cmd_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected command stream: value {cmd, ba, addr} and a mask of the bits that matter.
  typedef struct packed {
    logic [17:0] val;
    logic [17:0] mask;
  } exp_t;

  localparam logic [17:0] M_FULL = 18'h3FFFF;
  localparam logic [17:0] M_PRE  = {3'b111, 2'b11, 13'h0400};
  localparam logic [17:0] M_PALL = {3'b111, 2'b00, 13'h0400};

  exp_t q[$];
  bit   m_open [4];
  int   m_row  [4];
  int   pall_in_q;
  int   last_act [4];
  int   last_pre [4];
  int   cyc = 0;
  int   ready_mode = 1;
  int   stall_left = 0;

  function automatic logic [12:0] rw_addr(input int c);
    return 13'(((c >> 10) << 11) | (c & 'h3FF));
  endfunction

  task automatic push(input cmd_t c, input int ba, input int addr, input logic [17:0] mask);
    exp_t e;
    e.val  = {c, 2'(ba), 13'(addr)};
    e.mask = mask;
    q.push_back(e);
  endtask

  task automatic model_req(input bit w, input int b, input int r, input int c);
    if (!(m_open[b] && m_row[b] == r)) begin
      if (m_open[b]) push(PRE, b, 0, M_PRE);
      push(ACT, b, r, M_FULL);
      m_open[b] = 1'b1;
      m_row[b]  = r;
    end
    push(w ? WR : RD, b, int'(rw_addr(c)), M_FULL);
  endtask

  task automatic model_pall();
    if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) begin
      push(PALL, 0, 'h400, M_PALL);
      pall_in_q++;
    end
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; pall_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    pall_in_q = 0;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 1'b0; last_act[b] = -1000; last_pre[b] = -1000;
    end
    rst_n = 1'b1;
    #1;
    chk_eq("rst_valid", cmd_valid, 0);
    chk_eq("rst_cmd", cmd, NOP);
    chk_eq("rst_ba", cmd_ba, 0);
    chk_eq("rst_addr", cmd_addr, 0);
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_pall_ack", pall_ack, 0);
  endtask

  // Raise a request and/or precharge-all, hold until consumed (bounded wait).
  task automatic issue(input bit p, input bit r, input bit w, input int b, input int rw, input int c);
    int n = 0;
    bit got_a, got_r;
    if (p) model_pall();
    if (r) model_req(w, b, rw, c);
    pall_req = p; req = r; we = w;
    bank = 2'(b); row = 13'(rw); column = 11'(c);
    got_a = !p; got_r = !r;
    while (!(got_a && got_r) && n < 400) begin
      @(negedge clk);
      n++;
      if (pall_ack)  got_a = 1'b1;
      if (req_ready) got_r = 1'b1;
      @(posedge clk);
      #1;
      if (got_a) pall_req = 1'b0;
      if (got_r) req = 1'b0;
    end
    chk_eq("handshake_done", {30'd0, got_a, got_r}, 32'd3);
    pall_req = 1'b0; req = 1'b0;
  endtask

  // cmd_ready driver: always ready, forced stall of 3 valid cycles, or random.
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: cmd_ready = 1'b1;
        2: begin
          if (stall_left > 0) begin
            cmd_ready = 1'b0;
            if (cmd_valid) stall_left--;
          end else begin
            cmd_ready = 1'b1;
          end
        end
        default: cmd_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic [17:0] mon_obs, mon_held;
  bit          mon_hs, mon_stalled = 1'b0;
  exp_t        mon_e;

  // Monitor: protocol rules, expected command stream and per-bank timing gaps.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_stalled = 1'b0;
    end else begin
      mon_obs = {cmd, cmd_ba, cmd_addr};
      mon_hs  = cmd_valid && cmd_ready;
      if (!cmd_valid) chk_eq("nop_when_invalid", cmd, NOP);
      if (mon_stalled) begin
        chk_eq("stall_valid", cmd_valid, 1);
        chk_eq("stall_stable", mon_obs, mon_held);
      end
      mon_stalled = cmd_valid && !cmd_ready;
      mon_held    = mon_obs;
      chk_eq("req_ready", req_ready, mon_hs && (cmd == RD || cmd == WR));
      if (mon_hs) begin
        if (q.size() == 0) begin
          chk_eq("unexpected_cmd", mon_obs, 0);
        end else begin
          mon_e = q.pop_front();
          chk_eq("cmd", mon_obs & mon_e.mask, mon_e.val & mon_e.mask);
          case (cmd)
            ACT: begin
              chk_eq("trp_gap", cyc - last_pre[cmd_ba], (cyc - last_pre[cmd_ba] >= trp) ? cyc - last_pre[cmd_ba] : trp);
              last_act[cmd_ba] = cyc;
            end
            PRE: begin
              chk_eq("tras_gap", (cyc - last_act[cmd_ba]) >= tras, 1);
              last_pre[cmd_ba] = cyc;
            end
            RD, WR: chk_eq("trcd_gap", (cyc - last_act[cmd_ba]) >= trcd, 1);
            PALL: begin
              for (int b = 0; b < 4; b++) begin
                chk_eq("pall_tras_gap", (cyc - last_act[b]) >= tras, 1);
                last_pre[b] = cyc;
              end
              pall_in_q--;
            end
            default: ;
          endcase
        end
      end
      if (pall_ack) begin
        chk_eq("ack_with_req", pall_req, 1);
        chk_eq("ack_after_pall", pall_in_q, 0);
        for (int b = 0; b < 4; b++) chk_eq("ack_trp_gap", (cyc - last_pre[b]) >= trp, 1);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; pall_req = 1'b0; we = 1'b0;
    bank = 2'd0; row = 13'd0; column = 11'd0;
    trcd = 4'd2; trp = 4'd2; tras = 4'd5;
    do_reset();
    issue(1'b0, 1'b1, 1'b0, 1, 'h12, 'h34);
    issue(1'b0, 1'b1, 1'b1, 1, 'h12, 'h35);
    issue(1'b0, 1'b1, 1'b0, 1, 'h13, 'h10);
    issue(1'b0, 1'b1, 1'b0, 0, 'h05, 'h01);
    issue(1'b0, 1'b1, 1'b0, 2, 'h07, 'h02);
    issue(1'b1, 1'b0, 1'b0, 0, 0, 0);
    issue(1'b0, 1'b1, 1'b0, 0, 'h05, 'h03);
    issue(1'b1, 1'b1, 1'b0, 3, 'h09, 'h01);
    stall_left = 3;
    ready_mode = 2;
    issue(1'b0, 1'b1, 1'b0, 3, 'h09, 'h4FF);
    ready_mode = 1;
    issue(1'b1, 1'b0, 1'b0, 0, 0, 0);
    issue(1'b1, 1'b0, 1'b0, 0, 0, 0);
    for (int ep = 0; ep < 3; ep++) begin
      if (ep == 0) begin
        trcd = 4'd0; trp = 4'd1; tras = 4'd0;
      end else begin
        trcd = 4'($urandom_range(1, 7));
        trp  = 4'($urandom_range(1, 7));
        tras = 4'($urandom_range(1, 9));
      end
      ready_mode = 0;
      do_reset();
      for (int i = 0; i < 60; i++) begin
        int sel;
        sel = $urandom_range(0, 15);
        issue(sel < 3, sel != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2047));
      end
    end
    repeat (4) @(posedge clk);
    chk_eq("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
